// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I main controller: opcodes, FSM
// states, datapath select codes and the DECODE dispatch helper.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_JAL      = 4'd9,
    S_JALR     = 4'd10,
    S_BEQ      = 4'd11,
    S_LUI      = 4'd12,
    S_AUIPC    = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_DATA      = 2'b01,
    RES_ALURESULT = 2'b10
  } result_src_t;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RD1   = 2'b10,
    SRCA_ZERO  = 2'b11
  } alu_srca_t;

  typedef enum logic [1:0] {
    SRCB_RD2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } alu_srcb_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  // Dispatch from DECODE; unknown opcodes trap or are silently skipped.
  function automatic state_t decode_next(input logic [6:0] op, input logic trap_en);
    state_t s;
    case (op)
      OP_LOAD, OP_STORE: s = S_MEMADR;
      OP_RTYPE:          s = S_EXECR;
      OP_ITYPE:          s = S_EXECI;
      OP_JAL:            s = S_JAL;
      OP_JALR:           s = S_JALR;
      OP_BRANCH:         s = S_BEQ;
      OP_LUI:            s = S_LUI;
      OP_AUIPC:          s = S_AUIPC;
      default:           s = trap_en ? S_TRAP : S_FETCH;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter: increments on i_inc, wraps modulo 2^CNT_W,
// cleared by the asynchronous active-high reset.
module retire_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_count <= '0;
    else if (i_inc) r_count <= r_count + ONE;
  end

  assign o_count = r_count;

endmodule

// File: rtl/main_fsm_ext.sv
// Multi-cycle RV32I main control FSM with memory wait states, lui/auipc/jalr,
// a sticky illegal-opcode trap and a retired-instruction counter.
module main_fsm_ext
  import riscv_ctrl_pkg::*;
#(
  parameter bit USE_MEM_READY = 1'b1,
  parameter int CNT_W         = 32,
  parameter bit TRAP_EN       = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic             mem_ready,
  output logic             branch,
  output logic             pc_update,
  output logic             reg_write,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_req,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_srcA,
  output logic [1:0]       alu_srcB,
  output logic             adr_src,
  output logic [1:0]       alu_op,
  output logic             trap,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state_dbg
);

  state_t r_state;
  state_t w_next;
  logic   r_trap;
  logic   w_rdy;
  logic   w_retire;

  assign w_rdy = mem_ready | ~USE_MEM_READY;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_trap  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_trap  <= r_trap | (w_next == S_TRAP);
    end
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:                     if (w_rdy) w_next = S_DECODE;
      S_DECODE:                    w_next = decode_next(op, TRAP_EN);
      S_MEMADR:                    w_next = op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:                   if (w_rdy) w_next = S_MEMWB;
      S_MEMWRITE:                  if (w_rdy) w_next = S_FETCH;
      S_MEMWB, S_ALUWB, S_BEQ:     w_next = S_FETCH;
      S_EXECR, S_EXECI, S_JAL,
      S_LUI, S_AUIPC:              w_next = S_ALUWB;
      S_JALR:                      w_next = S_JAL;
      S_TRAP:                      w_next = S_TRAP;
      default:                     w_next = S_FETCH;
    endcase
  end

  always_comb begin
    branch     = 1'b0;
    pc_update  = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_req    = 1'b0;
    result_src = RES_ALUOUT;
    alu_srcA   = SRCA_PC;
    alu_srcB   = SRCB_RD2;
    adr_src    = 1'b0;
    alu_op     = ALUOP_ADD;
    case (r_state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_srcB   = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_write   = w_rdy;
        pc_update  = w_rdy;
      end
      S_DECODE: begin
        alu_srcA = SRCA_OLDPC;
        alu_srcB = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_srcA = SRCA_RD1;
        alu_srcB = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = w_rdy;
      end
      S_EXECR: begin
        alu_srcA = SRCA_RD1;
        alu_op   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_srcA = SRCA_RD1;
        alu_srcB = SRCB_IMM;
        alu_op   = ALUOP_FUNCT;
      end
      S_ALUWB: reg_write = 1'b1;
      S_JAL: begin
        alu_srcA  = SRCA_OLDPC;
        alu_srcB  = SRCB_FOUR;
        pc_update = 1'b1;
      end
      S_JALR: begin
        alu_srcA = SRCA_RD1;
        alu_srcB = SRCB_IMM;
      end
      S_BEQ: begin
        alu_srcA = SRCA_RD1;
        alu_op   = ALUOP_SUB;
        branch   = 1'b1;
      end
      S_LUI: begin
        alu_srcA = SRCA_ZERO;
        alu_srcB = SRCB_IMM;
      end
      S_AUIPC: begin
        alu_srcA = SRCA_OLDPC;
        alu_srcB = SRCB_IMM;
      end
      default: ;
    endcase
    // Reset also kills an in-flight access combinationally, before any edge.
    if (rst) begin
      branch    = 1'b0;
      pc_update = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      mem_req   = 1'b0;
    end
  end

  assign w_retire = (r_state == S_MEMWB) || (r_state == S_ALUWB) || (r_state == S_BEQ) ||
                    ((r_state == S_MEMWRITE) && w_rdy);

  retire_counter #(.CNT_W(CNT_W)) u_retire (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_retire),
    .o_count (instret)
  );

  assign trap      = r_trap;
  assign state_dbg = r_state;

endmodule

// File: tb/tb_main_fsm_ext.sv
// Randomized bench for main_fsm_ext: instance 0 ignores mem_ready and skips
// illegal opcodes; instance 1 has wait states, traps and a 4-bit counter.
module tb_main_fsm_ext;
  import riscv_ctrl_pkg::*;

  typedef struct packed {
    logic       branch, pc_update, reg_write, mem_write, ir_write, mem_req;
    logic [1:0] result_src, alu_srca, alu_srcb;
    logic       adr_src;
    logic [1:0] alu_op;
    logic       trap;
    logic [3:0] st;
  } ctl_t;

  logic clk;
  logic rst_in [2];
  logic mr_in  [2];
  logic [6:0] op_in [2];

  logic a_branch, a_pc_update, a_reg_write, a_mem_write, a_ir_write, a_mem_req, a_adr_src, a_trap;
  logic [1:0] a_result_src, a_alu_srca, a_alu_srcb, a_alu_op;
  logic [31:0] a_instret;
  logic [3:0] a_state_dbg;
  logic b_branch, b_pc_update, b_reg_write, b_mem_write, b_ir_write, b_mem_req, b_adr_src, b_trap;
  logic [1:0] b_result_src, b_alu_srca, b_alu_srcb, b_alu_op;
  logic [3:0] b_instret;
  logic [3:0] b_state_dbg;

  main_fsm_ext #(.USE_MEM_READY(1'b0), .CNT_W(32), .TRAP_EN(1'b0)) dut_a (
    .clk(clk), .rst(rst_in[0]), .op(op_in[0]), .mem_ready(mr_in[0]),
    .branch(a_branch), .pc_update(a_pc_update), .reg_write(a_reg_write), .mem_write(a_mem_write),
    .ir_write(a_ir_write), .mem_req(a_mem_req), .result_src(a_result_src), .alu_srcA(a_alu_srca),
    .alu_srcB(a_alu_srcb), .adr_src(a_adr_src), .alu_op(a_alu_op), .trap(a_trap),
    .instret(a_instret), .state_dbg(a_state_dbg));

  main_fsm_ext #(.USE_MEM_READY(1'b1), .CNT_W(4), .TRAP_EN(1'b1)) dut_b (
    .clk(clk), .rst(rst_in[1]), .op(op_in[1]), .mem_ready(mr_in[1]),
    .branch(b_branch), .pc_update(b_pc_update), .reg_write(b_reg_write), .mem_write(b_mem_write),
    .ir_write(b_ir_write), .mem_req(b_mem_req), .result_src(b_result_src), .alu_srcA(b_alu_srca),
    .alu_srcB(b_alu_srcb), .adr_src(b_adr_src), .alu_op(b_alu_op), .trap(b_trap),
    .instret(b_instret), .state_dbg(b_state_dbg));

  ctl_t        got_ctl [2];
  logic [31:0] got_cnt [2];
  assign got_ctl[0] = {a_branch, a_pc_update, a_reg_write, a_mem_write, a_ir_write, a_mem_req,
                       a_result_src, a_alu_srca, a_alu_srcb, a_adr_src, a_alu_op, a_trap, a_state_dbg};
  assign got_ctl[1] = {b_branch, b_pc_update, b_reg_write, b_mem_write, b_ir_write, b_mem_req,
                       b_result_src, b_alu_srca, b_alu_srcb, b_adr_src, b_alu_op, b_trap, b_state_dbg};
  assign got_cnt[0] = a_instret;
  assign got_cnt[1] = {28'd0, b_instret};

  // Instance parameters as the model sees them.
  bit          use_mr   [2] = '{1'b0, 1'b1};
  bit          trap_en  [2] = '{1'b0, 1'b1};
  logic [31:0] cnt_mask [2] = '{32'hFFFF_FFFF, 32'h0000_000F};

  // Model state: expected outputs for the current cycle, retired count, trap flag.
  ctl_t        exp_ctl [2];
  logic [31:0] exp_cnt [2];
  logic [31:0] cnt_m   [2];
  logic        trap_m  [2];
  int          cyc     [2];
  logic        chk_en;

  int n_checks = 0;
  int n_fail   = 0;
  int n_irw = 0, n_irw_nr = 0, n_rw = 0, n_mw = 0, n_mw_nr = 0;

  logic [6:0] ops_tab [9] = '{OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_JAL,
                              OP_BRANCH, OP_LUI, OP_AUIPC, OP_JALR};
  int         cpi_tab [9] = '{5, 4, 4, 4, 4, 3, 4, 4, 5};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Per-state output table.
  function automatic ctl_t model_ctl(input state_t s, input logic rdy, input logic trap_f);
    ctl_t c = '0;
    c.trap = trap_f;
    c.st   = s;
    case (s)
      S_FETCH:    begin c.mem_req = 1; c.alu_srcb = 2'b10; c.result_src = 2'b10;
                        c.ir_write = rdy; c.pc_update = rdy; end
      S_DECODE:   begin c.alu_srca = 2'b01; c.alu_srcb = 2'b01; end
      S_MEMADR:   begin c.alu_srca = 2'b10; c.alu_srcb = 2'b01; end
      S_MEMREAD:  begin c.mem_req = 1; c.adr_src = 1; end
      S_MEMWB:    begin c.result_src = 2'b01; c.reg_write = 1; end
      S_MEMWRITE: begin c.mem_req = 1; c.adr_src = 1; c.mem_write = rdy; end
      S_EXECR:    begin c.alu_srca = 2'b10; c.alu_op = 2'b10; end
      S_EXECI:    begin c.alu_srca = 2'b10; c.alu_srcb = 2'b01; c.alu_op = 2'b10; end
      S_ALUWB:    c.reg_write = 1;
      S_JAL:      begin c.alu_srca = 2'b01; c.alu_srcb = 2'b10; c.pc_update = 1; end
      S_JALR:     begin c.alu_srca = 2'b10; c.alu_srcb = 2'b01; end
      S_BEQ:      begin c.alu_srca = 2'b10; c.alu_op = 2'b01; c.branch = 1; end
      S_LUI:      begin c.alu_srca = 2'b11; c.alu_srcb = 2'b01; end
      S_AUIPC:    begin c.alu_srca = 2'b01; c.alu_srcb = 2'b01; end
      default:    ;
    endcase
    return c;
  endfunction

  function automatic ctl_t rst_vec();
    ctl_t c = model_ctl(S_FETCH, 1'b0, 1'b0);
    c.mem_req = 1'b0;
    return c;
  endfunction

  function automatic logic rnd_bit();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rnd_op();
    return 7'($urandom);
  endfunction

  function automatic logic [6:0] rnd_illegal();
    logic [6:0] o;
    bit hit;
    do begin
      o = rnd_op();
      hit = 0;
      for (int k = 0; k < 9; k++) if (o == ops_tab[k]) hit = 1;
    end while (hit);
    return o;
  endfunction

  // One clock of instance d spent in state s with the given inputs.
  task automatic step(input int d, input state_t s, input logic mr, input logic [6:0] o);
    logic rdy;
    mr_in[d] = mr;
    op_in[d] = o;
    rdy = mr | ~use_mr[d];
    if (s == S_TRAP) trap_m[d] = 1'b1;
    exp_ctl[d] = model_ctl(s, rdy, trap_m[d]);
    exp_cnt[d] = cnt_m[d];
    @(posedge clk); #1;
    cyc[d]++;
    if (s == S_MEMWB || s == S_ALUWB || s == S_BEQ || (s == S_MEMWRITE && rdy))
      cnt_m[d] = (cnt_m[d] + 1) & cnt_mask[d];
  endtask

  task automatic hold_rst(input int d, input int n);
    rst_in[d] = 1'b1;
    cnt_m[d] = 0;
    trap_m[d] = 1'b0;
    exp_ctl[d] = rst_vec();
    exp_cnt[d] = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Instruction-level sequence: wf FETCH waits, wm memory waits.
  task automatic run_instr(input int d, input logic [6:0] opc, input int wf_i, input int wm_i,
                           output int ncyc);
    int c0 = cyc[d];
    int wf = use_mr[d] ? wf_i : 0;
    int wm = use_mr[d] ? wm_i : 0;
    logic go = use_mr[d] ? 1'b1 : rnd_bit();
    repeat (wf) step(d, S_FETCH, 1'b0, rnd_op());
    step(d, S_FETCH, go, rnd_op());
    step(d, S_DECODE, rnd_bit(), opc);
    case (opc)
      OP_LOAD: begin
        step(d, S_MEMADR, rnd_bit(), opc);
        repeat (wm) step(d, S_MEMREAD, 1'b0, rnd_op());
        step(d, S_MEMREAD, use_mr[d] ? 1'b1 : rnd_bit(), rnd_op());
        step(d, S_MEMWB, rnd_bit(), rnd_op());
      end
      OP_STORE: begin
        step(d, S_MEMADR, rnd_bit(), opc);
        repeat (wm) step(d, S_MEMWRITE, 1'b0, rnd_op());
        step(d, S_MEMWRITE, use_mr[d] ? 1'b1 : rnd_bit(), rnd_op());
      end
      OP_RTYPE:  begin step(d, S_EXECR, rnd_bit(), rnd_op()); step(d, S_ALUWB, rnd_bit(), rnd_op()); end
      OP_ITYPE:  begin step(d, S_EXECI, rnd_bit(), rnd_op()); step(d, S_ALUWB, rnd_bit(), rnd_op()); end
      OP_JAL:    begin step(d, S_JAL, rnd_bit(), rnd_op()); step(d, S_ALUWB, rnd_bit(), rnd_op()); end
      OP_JALR:   begin step(d, S_JALR, rnd_bit(), rnd_op()); step(d, S_JAL, rnd_bit(), rnd_op());
                       step(d, S_ALUWB, rnd_bit(), rnd_op()); end
      OP_BRANCH: step(d, S_BEQ, rnd_bit(), rnd_op());
      OP_LUI:    begin step(d, S_LUI, rnd_bit(), rnd_op()); step(d, S_ALUWB, rnd_bit(), rnd_op()); end
      OP_AUIPC:  begin step(d, S_AUIPC, rnd_bit(), rnd_op()); step(d, S_ALUWB, rnd_bit(), rnd_op()); end
      default:   if (trap_en[d]) step(d, S_TRAP, rnd_bit(), rnd_op());
    endcase
    ncyc = cyc[d] - c0;
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("ctl[%0d] st=%0d", d, exp_ctl[d].st), 64'(got_ctl[d]), 64'(exp_ctl[d]));
        check($sformatf("instret[%0d]", d), 64'(got_cnt[d]), 64'(exp_cnt[d]));
      end
      if (b_ir_write) n_irw++;
      if (b_ir_write && !mr_in[1]) n_irw_nr++;
      if (b_reg_write) n_rw++;
      if (b_mem_write) n_mw++;
      if (b_mem_write && !mr_in[1]) n_mw_nr++;
    end
  end

  initial begin
    int n, s_irw, s_irw_nr, s_rw, s_mw, s_mw_nr;
    logic [6:0] o;
    chk_en = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mr_in[d] = 1'b0;
      op_in[d] = 7'd0;
      cyc[d] = 0;
      rst_in[d] = 1'b1;
      cnt_m[d] = 0;
      trap_m[d] = 1'b0;
      exp_ctl[d] = rst_vec();
      exp_cnt[d] = 0;
    end
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    // Instance 0: fixed program, then random mix including illegal skips.
    rst_in[0] = 1'b0;
    for (int i = 0; i < 9; i++) begin
      run_instr(0, ops_tab[i], 0, 0, n);
      check($sformatf("cpi[%0d]", i), 64'(n), 64'(cpi_tab[i]));
    end
    check("a_instret_after_9", 64'(a_instret), 64'd9);
    for (int i = 0; i < 60; i++) begin
      o = ($urandom_range(0, 4) == 0) ? rnd_illegal() : ops_tab[$urandom_range(0, 8)];
      run_instr(0, o, 0, 0, n);
    end
    hold_rst(0, 2);

    // Instance 1: lw with 3 FETCH and 2 MEMREAD waits.
    rst_in[1] = 1'b0;
    s_irw = n_irw; s_irw_nr = n_irw_nr; s_rw = n_rw;
    run_instr(1, OP_LOAD, 3, 2, n);
    check("lw_wait_cycles", 64'(n), 64'd10);
    check("lw_ir_write_pulses", 64'(n_irw - s_irw), 64'd1);
    check("lw_ir_write_not_ready", 64'(n_irw_nr - s_irw_nr), 64'd0);
    check("lw_reg_write_pulses", 64'(n_rw - s_rw), 64'd1);

    s_mw = n_mw; s_mw_nr = n_mw_nr;
    run_instr(1, OP_STORE, 0, 2, n);
    check("sw_mem_write_pulses", 64'(n_mw - s_mw), 64'd1);
    check("sw_mem_write_not_ready", 64'(n_mw_nr - s_mw_nr), 64'd0);

    for (int i = 0; i < 80; i++)
      run_instr(1, ops_tab[$urandom_range(0, 8)], $urandom_range(0, 3), $urandom_range(0, 3), n);

    // 4-bit counter wrap.
    hold_rst(1, 2);
    rst_in[1] = 1'b0;
    repeat (15) run_instr(1, OP_RTYPE, 0, 0, n);
    check("wrap_at_15", 64'(b_instret), 64'd15);
    run_instr(1, OP_RTYPE, 0, 0, n);
    check("wrap_to_0", 64'(b_instret), 64'd0);

    // Illegal opcode trap held for 20 cycles.
    hold_rst(1, 2);
    rst_in[1] = 1'b0;
    run_instr(1, OP_RTYPE, 0, 0, n);
    run_instr(1, OP_BRANCH, 1, 0, n);
    s_irw = n_irw; s_rw = n_rw; s_mw = n_mw;
    run_instr(1, 7'b1111111, 0, 0, n);
    repeat (19) step(1, S_TRAP, rnd_bit(), rnd_op());
    check("trap_sticky", 64'(b_trap), 64'd1);
    check("trap_instret_frozen", 64'(b_instret), 64'd2);
    check("trap_no_reg_write", 64'(n_rw - s_rw), 64'd0);
    check("trap_no_mem_write", 64'(n_mw - s_mw), 64'd0);
    check("trap_one_fetch_only", 64'(n_irw - s_irw), 64'd1);
    hold_rst(1, 1);
    check("trap_cleared_by_rst", 64'(b_trap), 64'd0);
    rst_in[1] = 1'b0;
    run_instr(1, OP_RTYPE, 0, 0, n);
    check("resume_after_trap", 64'(b_instret), 64'd1);

    // Async reset in the middle of a store wait.
    step(1, S_FETCH, 1'b1, rnd_op());
    step(1, S_DECODE, rnd_bit(), OP_STORE);
    step(1, S_MEMADR, rnd_bit(), OP_STORE);
    step(1, S_MEMWRITE, 1'b0, rnd_op());
    s_mw = n_mw;
    mr_in[1] = 1'b0;
    exp_ctl[1] = model_ctl(S_MEMWRITE, 1'b0, 1'b0);
    exp_cnt[1] = cnt_m[1];
    #2;
    rst_in[1] = 1'b1;
    cnt_m[1] = 0;
    exp_ctl[1] = rst_vec();
    exp_cnt[1] = 0;
    #1;
    check("async_rst_enables", 64'({b_branch, b_pc_update, b_reg_write, b_mem_write, b_ir_write, b_mem_req}), 64'd0);
    check("async_rst_state", 64'(b_state_dbg), 64'(S_FETCH));
    check("async_rst_instret", 64'(b_instret), 64'd0);
    @(posedge clk); #1;
    hold_rst(1, 2);
    check("async_rst_no_write", 64'(n_mw - s_mw), 64'd0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/main_fsm_ext.md
Name: main_fsm_ext

Overview:
- Parametrised successor to the multi-cycle RV32I main control FSM.
- Adds:
  - async reset
  - memory-ready handshake with wait states
  - lui/auipc/jalr support
  - sticky illegal-opcode trap
  - retired-instruction counter
- Sits in the multi-cycle controller beside the ALU decoder. It drives the datapath mux selects and write enables from op[6:0].

Parameters:
USE_MEM_READY, 1, 1: memory accesses wait for mem_ready; 0: mem_ready ignored (treated as 1).
CNT_W, 32, width of instret counter (1..64).
TRAP_EN, 1, 1: unknown opcode enters TRAP; 0: unknown opcode returns to FETCH with no writes.

Ports:
clk  in  1  clock
rst  in  1  async active-high reset
op  in  7  instruction opcode, valid from DECODE onward
mem_ready  in  1  memory completes current access this cycle
branch  out  1  conditional-branch PC enable request
pc_update  out  1  unconditional PC write
reg_write  out  1  register file write
mem_write  out  1  data memory write
ir_write  out  1  instruction register/OldPC load
mem_req  out  1  memory access in progress
result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult
alu_srcA  out  2  00 PC, 01 OldPC, 10 RD1, 11 zero
alu_srcB  out  2  00 RD2, 01 ImmExt, 10 const 4
adr_src  out  1  0 PC, 1 Result
alu_op  out  2  00 add, 01 sub, 10 funct-decoded
trap  out  1  sticky illegal-opcode flag
instret  out  CNT_W  retired instruction count
state_dbg  out  4  current state encoding

Behaviour:
- Moore FSM. Outputs are combinational from state, except where gated by mem_ready or rst.
- Unlisted signals are 0/00.
- Reset (async, any state): state=FETCH, trap=0, instret=0.
  - While rst=1: all write enables (pc_update, ir_write, reg_write, mem_write, branch) and mem_req are forced 0.
  - Selects take FETCH values.
- Let rdy = mem_ready | ~USE_MEM_READY.
- FETCH: mem_req=1, adr_src=0, alu_srcA=00, alu_srcB=10, alu_op=00, result_src=10.
  - ir_write=rdy, pc_update=rdy.
  - Stays in FETCH until rdy, then goes to DECODE.
- DECODE: alu_srcA=01, alu_srcB=01, alu_op=00. Next state by op:
  - 0000011/0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1101111 → JAL
  - 1100111 → JALR
  - 1100011 → BEQ
  - 0110111 → LUI
  - 0010111 → AUIPC
  - other → TRAP (TRAP_EN=1) or FETCH (TRAP_EN=0)
- MEMADR: alu_srcA=10, alu_srcB=01, alu_op=00. Goes to MEMREAD if op[5]=0, else MEMWRITE.
- MEMREAD: mem_req=1, result_src=00, adr_src=1. Holds until rdy, then → MEMWB.
- MEMWB: result_src=01, reg_write=1 → FETCH.
- MEMWRITE: mem_req=1, result_src=00, adr_src=1, mem_write=rdy. Holds until rdy, then → FETCH.
- EXECR: alu_srcA=10, alu_srcB=00, alu_op=10 → ALUWB.
- EXECI: alu_srcA=10, alu_srcB=01, alu_op=10 → ALUWB.
- ALUWB: result_src=00, reg_write=1 → FETCH.
- JAL: alu_srcA=01, alu_srcB=10, alu_op=00, result_src=00, pc_update=1 → ALUWB.
- JALR: alu_srcA=10, alu_srcB=01, alu_op=00 → JAL (ALUOut then holds the rs1+imm target).
- BEQ: alu_srcA=10, alu_srcB=00, alu_op=01, result_src=00, branch=1 → FETCH.
- LUI: alu_srcA=11, alu_srcB=01, alu_op=00 → ALUWB.
- AUIPC: alu_srcA=01, alu_srcB=01, alu_op=00 → ALUWB.
- TRAP: no writes, trap=1 (sticky). Held until rst.
- instret:
  - Increments by 1 on each transition into FETCH from MEMWB, MEMWRITE(rdy), ALUWB or BEQ.
  - Wraps modulo 2^CNT_W.
  - Not incremented for TRAP_EN=0 illegal skips.
- mem_ready outside mem_req states is ignored.
- Reset asserted mid-wait abandons the access with no write.
- op changes outside DECODE/MEMADR have no effect.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants
  - 4-bit state encodings
  - result_src/alu_srcA/alu_srcB/alu_op encodings
- One sub-module: retire_counter (CNT_W-bit, inc enable, async reset, wrap).

Test Plan:
- USE_MEM_READY=0, sequence lw,sw,R,I,jal,beq,lui,auipc,jalr:
  - Cycles per instruction 5,4,4,4,4,3,4,4,5.
  - instret=9 at end.
  - State sequences and outputs match the per-state table.
- USE_MEM_READY=1, lw with mem_ready low 3 cycles in FETCH and 2 in MEMREAD:
  - ir_write/pc_update pulse only in the ready cycle.
  - Total 10 cycles.
  - reg_write once.
- sw with mem_ready delayed 2 cycles → mem_write high for exactly 1 cycle, coincident with mem_ready.
- op=7'b1111111 in DECODE, TRAP_EN=1:
  - trap=1, held for 20 cycles, no enables, instret unchanged.
  - rst clears trap and resumes at FETCH.
- rst asserted asynchronously mid-MEMWRITE wait:
  - All enables 0 immediately, state_dbg=FETCH, instret=0.
- CNT_W=4, 16 R-type instructions → instret wraps 15→0.
